// File: rtl/fib_seq_checker.sv
// Handshaked Fibonacci membership checker: walks the sequence one term per cycle
// and reports membership and index. Optional FLOOR output under `define FIB_FLOOR_EN.
module fib_seq_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 7
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] N,
  output logic             BUSY,
  output logic             DONE,
  output logic             O,
  output logic [IDX_W-1:0] INDEX
`ifdef FIB_FLOOR_EN
  ,
  output logic [WIDTH-1:0] FLOOR
`endif
);

  typedef enum logic {
    S_IDLE,
    S_ITER
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic               done_q, done_d;
  logic               o_q, o_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH:0]     sum;
`ifdef FIB_FLOOR_EN
  logic [WIDTH-1:0]   floor_q, floor_d;
`endif

  // Extra carry bit detects when the next term no longer fits in WIDTH bits.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      o_q     <= 1'b0;
      idx_q   <= '0;
`ifdef FIB_FLOOR_EN
      floor_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      done_q  <= done_d;
      o_q     <= o_d;
      idx_q   <= idx_d;
`ifdef FIB_FLOOR_EN
      floor_q <= floor_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    done_d  = 1'b0;
    o_d     = o_q;
    idx_d   = idx_q;
`ifdef FIB_FLOOR_EN
    floor_d = floor_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          n_d   = N;
          o_d   = 1'b0;
          idx_d = '0;
`ifdef FIB_FLOOR_EN
          floor_d = '0;
`endif
          if (N == '0) begin
            // F(0)=0 resolves immediately without entering ITER.
            done_d = 1'b1;
            o_d    = 1'b1;
          end else begin
            a_d     = '0;
            b_d     = WIDTH'(1);
            k_d     = IDX_W'(1);
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        if (b_q == n_q) begin
          o_d     = 1'b1;
          idx_d   = k_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef FIB_FLOOR_EN
          floor_d = n_q;
`endif
        end else if ((b_q > n_q) || sum[WIDTH]) begin
          o_d     = 1'b0;
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef FIB_FLOOR_EN
          floor_d = (b_q > n_q) ? a_q : b_q;
`endif
        end else begin
          a_d = b_q;
          b_d = sum[WIDTH-1:0];
          k_d = k_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY  = (state_q == S_ITER);
  assign DONE  = done_q;
  assign O     = o_q;
  assign INDEX = idx_q;
`ifdef FIB_FLOOR_EN
  assign FLOOR = floor_q;
`endif

endmodule

// File: tb/tb_fib_seq_checker.sv
// Self-checking bench for fib_seq_checker: table vectors, hand sequences for
// handshake/reset corners, and randomized operands against a lookup-table model.
module tb_fib_seq_checker;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [31:0] N = '0;

  logic        busy32, done32, o32;
  logic [6:0]  idx32;
  logic        busy8, done8, o8;
  logic [6:0]  idx8;
`ifdef FIB_FLOOR_EN
  logic [31:0] floor32;
  logic [7:0]  floor8;
`endif

  logic        sel = 1'b0;
  logic        c_busy, c_done, c_o;
  logic [6:0]  c_idx;
`ifdef FIB_FLOOR_EN
  logic [31:0] c_floor;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  fib_seq_checker #(.WIDTH(32), .IDX_W(7)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .N(N),
    .BUSY(busy32), .DONE(done32), .O(o32), .INDEX(idx32)
`ifdef FIB_FLOOR_EN
    , .FLOOR(floor32)
`endif
  );

  fib_seq_checker #(.WIDTH(8), .IDX_W(7)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .N(N[7:0]),
    .BUSY(busy8), .DONE(done8), .O(o8), .INDEX(idx8)
`ifdef FIB_FLOOR_EN
    , .FLOOR(floor8)
`endif
  );

  always_comb begin
    c_busy = sel ? busy8 : busy32;
    c_done = sel ? done8 : done32;
    c_o    = sel ? o8 : o32;
    c_idx  = sel ? idx8 : idx32;
`ifdef FIB_FLOOR_EN
    c_floor = sel ? {24'd0, floor8} : floor32;
`endif
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: tabulate every representable Fibonacci term, then search it.
  function automatic void model(input longint unsigned n, input int w, output bit o,
                                output int idx, output int lat, output longint unsigned fl);
    longint unsigned f[0:99];
    longint unsigned lim;
    int kmax;
    lim = 64'd1 << w;
    f[0] = 0;
    f[1] = 1;
    kmax = 1;
    while (f[kmax-1] + f[kmax] < lim) begin
      f[kmax+1] = f[kmax-1] + f[kmax];
      kmax++;
    end
    if (n == 0) begin
      o = 1'b1; idx = 0; lat = 1; fl = 0;
      return;
    end
    o = 1'b0; idx = 0; lat = kmax + 1; fl = f[kmax];
    for (int k = 1; k <= kmax; k++) begin
      if (f[k] >= n) begin
        if (f[k] == n) begin
          o = 1'b1; idx = k; fl = n;
        end else begin
          fl = f[k-1];
        end
        lat = k + 1;
        break;
      end
    end
  endfunction

  function automatic longint unsigned fib_of(input int k);
    longint unsigned x, y, t;
    x = 0;
    y = 1;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of cycle t+1.
  task automatic issue(input logic [31:0] n);
    START = 1'b1;
    N = n;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Returns at the negedge of the DONE cycle (or after the cycle budget).
  task automatic await_result(input string tag, input bit eo, input int eidx, input int elat,
                              input longint unsigned efl, input bit noise);
    int got;
    got = 0;
    for (int j = 1; j <= 120; j++) begin
      if (c_done) begin
        got = j;
        break;
      end
      check({tag, "_busy"}, 64'(c_busy), 64'd1);
      START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) N = $urandom;
      @(negedge CLK);
    end
    START = 1'b0;
    if (got == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_lat"}, 64'(got), 64'(elat));
    check({tag, "_o"}, 64'(c_o), 64'(eo));
    check({tag, "_index"}, 64'(c_idx), 64'(eidx));
    check({tag, "_busy_done"}, 64'(c_busy), 64'd0);
`ifdef FIB_FLOOR_EN
    check({tag, "_floor"}, 64'(c_floor), efl);
`else
    if (efl == 64'hFFFF_FFFF_FFFF_FFFF) $display("unexpected floor sentinel");
`endif
  endtask

  task automatic run_model(input string tag, input longint unsigned n, input int w, input bit noise);
    bit eo;
    int eidx, elat;
    longint unsigned efl;
    model(n, w, eo, eidx, elat, efl);
    issue(32'(n));
    await_result(tag, eo, eidx, elat, efl, noise);
  endtask

  typedef struct {
    logic [31:0]     n;
    bit              o;
    int              idx;
    int              lat;
    longint unsigned fl;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'd0,          1'b1, 0,  1,  64'd0};
    vecs[1]  = '{32'd1,          1'b1, 1,  2,  64'd1};
    vecs[2]  = '{32'd2,          1'b1, 3,  4,  64'd2};
    vecs[3]  = '{32'd3,          1'b1, 4,  5,  64'd3};
    vecs[4]  = '{32'd4,          1'b0, 0,  6,  64'd3};
    vecs[5]  = '{32'd21,         1'b1, 8,  9,  64'd21};
    vecs[6]  = '{32'd22,         1'b0, 0,  10, 64'd21};
    vecs[7]  = '{32'd8,          1'b1, 6,  7,  64'd8};
    vecs[8]  = '{32'd1000,       1'b0, 0,  18, 64'd987};
    vecs[9]  = '{32'd2971215073, 1'b1, 47, 48, 64'd2971215073};
    vecs[10] = '{32'hFFFFFFFF,   1'b0, 0,  48, 64'd2971215073};

    repeat (3) @(negedge CLK);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_o", 64'(o32), 64'd0);
    check("rst_index", 64'(idx32), 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    foreach (vecs[i]) begin
      issue(vecs[i].n);
      await_result($sformatf("vec%0d", i), vecs[i].o, vecs[i].idx, vecs[i].lat, vecs[i].fl, 1'b0);
      @(negedge CLK);
      check($sformatf("vec%0d_done_pulse", i), 64'(c_done), 64'd0);
      check($sformatf("vec%0d_o_hold", i), 64'(c_o), 64'(vecs[i].o));
      check($sformatf("vec%0d_idx_hold", i), 64'(c_idx), 64'(vecs[i].idx));
    end

    // START pulses while busy must not disturb the running check.
    issue(32'd21);
    await_result("noise21", 1'b1, 8, 9, 64'd21, 1'b1);
    @(negedge CLK);

    // Back-to-back: new START in the DONE cycle.
    issue(32'd21);
    await_result("b2b_first", 1'b1, 8, 9, 64'd21, 1'b0);
    issue(32'd8);
    await_result("b2b_second", 1'b1, 6, 7, 64'd8, 1'b0);
    @(negedge CLK);

    for (int r = 0; r < 150; r++) begin
      longint unsigned n;
      case ($urandom_range(0, 2))
        0: n = fib_of($urandom_range(0, 47));
        1: n = (fib_of($urandom_range(0, 47)) + 1) & 64'hFFFF_FFFF;
        default: n = 64'($urandom >> $urandom_range(0, 31));
      endcase
      run_model($sformatf("rnd%0d", r), n, 32, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
    end

    // Asynchronous reset mid-ITER after a hit left O/INDEX non-zero.
    issue(32'd21);
    await_result("pre_rst", 1'b1, 8, 9, 64'd21, 1'b0);
    @(negedge CLK);
    issue(32'd1000);
    repeat (5) @(negedge CLK);
    check("mid_busy", 64'(busy32), 64'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_busy", 64'(busy32), 64'd0);
    check("arst_done", 64'(done32), 64'd0);
    check("arst_o", 64'(o32), 64'd0);
    check("arst_index", 64'(idx32), 64'd0);
`ifdef FIB_FLOOR_EN
    check("arst_floor", 64'(floor32), 64'd0);
`endif
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      check("post_rst_done", 64'(done32), 64'd0);
      check("post_rst_busy", 64'(busy32), 64'd0);
    end

    sel = 1'b1;
    issue(32'd233);
    await_result("w8_233", 1'b1, 13, 14, 64'd233, 1'b0);
    issue(32'd255);
    await_result("w8_255", 1'b0, 0, 14, 64'd233, 1'b0);
    for (int r = 0; r < 30; r++) begin
      @(negedge CLK);
      run_model($sformatf("w8rnd%0d", r), 64'($urandom_range(0, 255)), 8, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
